// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side packer.
package fifo_pkg;

    localparam int FIFO_WIDTH = 4;
    localparam int FIFO_BEATS = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_timeout.sv
// Idle counter for the read packer; hit_o acts as an automatic flush request.
// Compiled only when FIFO_RD_PACK_TIMEOUT_EN is defined.
`ifdef FIFO_RD_PACK_TIMEOUT_EN
module fifo_rd_timeout #(
    parameter int TIMEOUT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic hit_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          at_limit;

    // Fires on the TIMEOUT-th consecutive idle cycle; saturates until run_i drops.
    assign at_limit = (cnt_q == CW'(TIMEOUT - 1));
    assign hit_o    = run_i && at_limit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!run_i) begin
            cnt_q <= '0;
        end else if (!at_limit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs BEATS of them into one valid/ready output word.
// FIFO_RD_PACK_TIMEOUT_EN adds an idle-timeout auto-flush of partial words.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = FIFO_WIDTH,
    parameter int BEATS   = FIFO_BEATS,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = $clog2(BEATS + 1)
) (
    input  logic                   rd_clk_i,
    input  logic                   reset_i,
    input  logic                   fifo_empty_i,
    input  logic [WIDTH-1:0]       fifo_rdata_i,
    output logic                   fifo_rd_en_o,
    input  logic                   flush_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [WIDTH*BEATS-1:0] m_data_o,
    output logic [CNT_W-1:0]       m_count_o,
    output logic                   busy_o
);

    localparam int DW = WIDTH * BEATS;

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             flush_pend_q, flush_pend_d;
    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] fill_lvl;
    logic             rd_en;
    logic             flush_req;
    logic             timeout_hit;

`ifdef FIFO_RD_PACK_TIMEOUT_EN
    logic idle_run;

    assign idle_run = (state_q == FILL) && (captured_q != '0) && !pending_q;

    fifo_rd_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i(rd_clk_i),
        .rst_i(reset_i),
        .run_i(idle_run),
        .hit_o(timeout_hit)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // Beats already owned by this word, including one still in flight from the FIFO.
    assign fill_lvl = captured_q + CNT_W'(pending_q);
    assign rd_en    = !reset_i && (state_q == FILL) && !fifo_empty_i
                      && (fill_lvl < CNT_W'(BEATS)) && !flush_pend_q;

    always_comb begin
        state_d      = state_q;
        captured_d   = captured_q;
        count_d      = count_q;
        pending_d    = rd_en;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        flush_req    = 1'b0;
        case (state_q)
            FILL: begin
                if (pending_q) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (captured_q == CNT_W'(b)) data_d[b*WIDTH +: WIDTH] = fifo_rdata_i;
                    end
                    captured_d = captured_q + 1'b1;
                end
                flush_req = flush_pend_q || ((flush_i || timeout_hit) && (fill_lvl != '0));
                // A completing capture wins over a flush: the word goes out full.
                if (pending_q && (captured_q == CNT_W'(BEATS - 1))) begin
                    state_d      = HOLD;
                    count_d      = CNT_W'(BEATS);
                    flush_pend_d = 1'b0;
                end else if (flush_req && !pending_q) begin
                    state_d      = HOLD;
                    count_d      = captured_q;
                    flush_pend_d = 1'b0;
                end else if (flush_req) begin
                    flush_pend_d = 1'b1;
                end
            end
            HOLD: begin
                if (m_ready_i) begin
                    state_d    = FILL;
                    captured_d = '0;
                    count_d    = '0;
                    data_d     = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge rd_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= FILL;
            captured_q   <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            captured_q   <= captured_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = (state_q == HOLD);
    assign m_data_o     = data_q;
    assign m_count_o    = count_q;
    assign busy_o       = (captured_q != '0) || pending_q;

endmodule
